alu_dispatch: RTL and testbench

//  Initiator side of the 8-bit pipelined ALU port (op1/op2/fn -> result/zero).
//  - Accepts one operation per valid/ready request, drives and holds the ALU operands,

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_dispatch.sv | 91 +++++++++
 tb/tb_alu_dispatch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU port: function codes, dispatcher state encoding
// and the ALU's registered output latencies.
package alu_pkg;

  localparam logic [1:0] FN_ADD = 2'd0;
  localparam logic [1:0] FN_SUB = 2'd1;
  localparam logic [1:0] FN_MUL = 2'd2;
  localparam logic [1:0] FN_DIV = 2'd3;

  localparam int ALU_LAT_RES  = 1;
  localparam int ALU_LAT_ZERO = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Divide-by-zero never reaches the ALU; the dispatcher answers it directly.
  function automatic logic is_div0(input logic [1:0] fn, input logic op2_zero);
    return (fn == FN_DIV) && op2_zero;
  endfunction

endpackage

// File: rtl/alu_dispatch.sv
// Initiator for the pipelined ALU: takes one request, holds operands through the
// ALU latency, then presents result/zero/tag on a valid/ready response.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_op1,
  input  logic [WIDTH-1:0] req_op2,
  input  logic [1:0]       req_fn,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [1:0]       alu_fn,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  state_t state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_fn     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_tag   <= req_tag;
            if (is_div0(req_fn, req_op2 == '0)) begin
              // ALU operands stay untouched so the ALU sees no spurious op.
              rsp_result <= '1;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end else begin
              alu_op1 <= req_op1;
              alu_op2 <= req_op2;
              alu_fn  <= req_fn;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT1;
        ST_WAIT1: state <= ST_WAIT2;
        ST_WAIT2: begin
          // Both result (1 edge) and zero (2 edges) have settled by now.
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch driving a behavioural registered ALU.
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_op1, req_op2;
  logic [1:0]       req_fn;
  logic [TAG_W-1:0] req_tag;
  logic [WIDTH-1:0] alu_op1, alu_op2;
  logic [1:0]       alu_fn;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   hs_count = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_fn(req_fn), .req_tag(req_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_fn(alu_fn),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  // Behavioural ALU: result one edge after operands, zero one edge after result.
  always @(posedge clk) begin
    case (alu_fn)
      FN_ADD:  alu_result <= alu_op1 + alu_op2;
      FN_SUB:  alu_result <= alu_op1 - alu_op2;
      FN_MUL:  alu_result <= alu_op1 * alu_op2;
      default: alu_result <= (alu_op2 == 0) ? 8'hFF : alu_op1 / alu_op2;
    endcase
    alu_zero <= (alu_result == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got result %0h, expected no response", rsp_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_result", rsp_result, e.result);
        check("rsp_zero",   rsp_zero,   e.zero);
        check("rsp_err",    rsp_err,    e.err);
        check("rsp_tag",    rsp_tag,    e.tag);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] fn,
                      input logic [2:0] tag, input logic [7:0] eres, input logic ez,
                      input logic eerr, input int elat, input int stall);
    exp_t e;
    int cyc;
    logic [7:0] held;
    e.result = eres; e.zero = ez; e.err = eerr; e.tag = tag;
    @(negedge clk);
    req_valid = 1'b1; req_op1 = a; req_op2 = b; req_fn = fn; req_tag = tag;
    exp_q.push_back(e);
    if (stall > 0) rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("req_ready_after_accept", req_ready, 1'b0);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, elat);
    held = rsp_result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_result", rsp_result, held);
      check("stall_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", rsp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    int hs0;
    reset_n = 1'b0; req_valid = 1'b0; req_op1 = '0; req_op2 = '0; req_fn = '0;
    req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_op1", alu_op1, 8'd0);
    check("rst_alu_fn", alu_fn, 2'd0);
    check("rst_rsp_result", rsp_result, 8'd0);
    reset_n = 1'b1;

    send(8'd20, 8'd22, FN_ADD, 3'd5, 8'd42, 1'b0, 1'b0, 3, 0);
    send(8'd7,  8'd7,  FN_SUB, 3'd1, 8'd0,  1'b1, 1'b0, 3, 0);
    send(8'd1,  8'd1,  FN_ADD, 3'd2, 8'd2,  1'b0, 1'b0, 3, 0);
    send(8'd16, 8'd17, FN_MUL, 3'd3, 8'h10, 1'b0, 1'b0, 3, 0);
    send(8'd3,  8'd5,  FN_SUB, 3'd4, 8'hFE, 1'b0, 1'b0, 3, 0);

    // Divide by zero: answered at once, ALU operands keep the SUB 3-5 values.
    send(8'd9, 8'd0, FN_DIV, 3'd6, 8'hFF, 1'b0, 1'b1, 0, 0);
    check("div0_alu_op1", alu_op1, 8'd3);
    check("div0_alu_op2", alu_op2, 8'd5);
    check("div0_alu_fn",  alu_fn,  FN_SUB);

    hs0 = hs_count;
    send(8'd100, 8'd7, FN_DIV, 3'd7, 8'd14, 1'b0, 1'b0, 3, 6);
    check("stall_handshakes", hs_count - hs0, 1);

    // Reset during WAIT1 discards the op.
    @(negedge clk);
    req_valid = 1'b1; req_op1 = 8'd50; req_op2 = 8'd60; req_fn = FN_ADD; req_tag = 3'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_alu_op1", alu_op1, 8'd0);
    check("midrst_alu_op2", alu_op2, 8'd0);
    check("midrst_alu_fn", alu_fn, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'd3, 8'd4, FN_ADD, 3'd1, 8'd7, 1'b0, 1'b0, 3, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
